// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one TX FIFO between NUM_REQ byte producers and drains it into the
//   UART transmitter. A round-robin arbiter owns the FIFO write strobe and a
//   drain FSM owns the FIFO read strobe; a pop always takes precedence over a
//   push, so the two strobes are never asserted together.
//   Optional build macro: UART_SCHED_PRIO0_EN gives producer 0 strict
//   priority while producers 1..NUM_REQ-1 keep rotating among themselves.
module uart_tx_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [DATA_BITS-1:0]         fifo_wdata,
    output logic                         fifo_push,
    input  logic                         fifo_full,
    output logic                         fifo_pop,
    input  logic [DATA_BITS-1:0]         fifo_rdata,
    input  logic                         fifo_empty,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic                         tx_start,
    input  logic                         tx_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef UART_SCHED_PRIO0_EN
    localparam bit PRIO0_EN = 1'b1;
`else
    localparam bit PRIO0_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_LOAD,
        S_ACK,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 fifo_pop_q, fifo_pop_d;

    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;
    logic                 grant_en;

    // Index base+off wrapped into 0..NUM_REQ-1 (off is always < NUM_REQ).
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int               off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // Arbiter: pick the first pending producer at or after rr_ptr (producer 0
    // short-circuits the search and is skipped by the rotation when it has
    // strict priority).
    always_comb begin
        logic [PTR_W-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        if (PRIO0_EN && req[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = wrap_add(rr_ptr_q, k);
                if (!win_found && !(PRIO0_EN && idx == '0) && req[idx]) begin
                    win_found = 1'b1;
                    win_idx   = idx;
                end
            end
        end
    end

    // Grant/push decode and pointer advance; a cycle spent popping blocks the push.
    always_comb begin
        int nxt;
        grant_en   = !reset && !fifo_full && win_found && (state_q != S_POP);
        grant      = '0;
        fifo_push  = 1'b0;
        fifo_wdata = '0;
        rr_ptr_d   = rr_ptr_q;
        nxt        = 0;
        if (grant_en) begin
            grant      = NUM_REQ'(1) << win_idx;
            fifo_push  = 1'b1;
            fifo_wdata = req_data[int'(win_idx)*DATA_BITS +: DATA_BITS];
            if (!(PRIO0_EN && win_idx == '0)) begin
                nxt = int'(win_idx) + 1;
                if (nxt >= NUM_REQ) nxt = PRIO0_EN ? 1 : 0;
                rr_ptr_d = PTR_W'(nxt);
            end
        end
    end

    // Drain FSM next state: pop, let the FIFO read data settle for a cycle,
    // then launch the frame and follow the transmitter's busy handshake.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        fifo_pop_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    state_d    = S_POP;
                    fifo_pop_d = 1'b1;
                end
            end
            S_POP: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d    = S_LOAD;
                tx_data_d  = fifo_rdata;
                tx_start_d = 1'b1;
            end
            S_LOAD: begin
                state_d = S_ACK;
            end
            S_ACK: begin
                if (tx_busy) state_d = S_DONE;
            end
            S_DONE: begin
                if (!tx_busy) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pointer and registered FSM outputs; reset drops any popped byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            fifo_pop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            fifo_pop_q <= fifo_pop_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign fifo_pop = fifo_pop_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
//   Scoreboard bench: a FIFO model and a transmitter model surround the DUT,
//   a reference arbiter predicts each granted producer and byte, and a
//   negedge monitor compares pushes, pops and frame starts against it.
module tb_uart_tx_scheduler;

    localparam int N  = 4;
    localparam int DB = 8;

`ifdef UART_SCHED_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*DB-1:0] req_data;
    logic [DB-1:0] pdata [N];
    logic [N-1:0]  grant;
    logic [DB-1:0] fifo_wdata;
    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_pop;
    logic [DB-1:0] fifo_rdata = '0;
    logic          fifo_empty;
    logic [DB-1:0] tx_data;
    logic          tx_start;
    logic          tx_busy = 1'b0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(N), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .fifo_wdata(fifo_wdata),
        .fifo_push (fifo_push),
        .fifo_full (fifo_full),
        .fifo_pop  (fifo_pop),
        .fifo_rdata(fifo_rdata),
        .fifo_empty(fifo_empty),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy)
    );

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*DB +: DB] = pdata[i];
    end

    // ---------------- FIFO model ----------------
    logic [DB-1:0] fq [$];
    int            fcnt = 0;
    int            depth = 16;
    logic          force_full = 1'b0;

    assign fifo_full  = force_full || (fcnt >= depth);
    assign fifo_empty = (fcnt == 0);

    always @(posedge clk) begin
        if (fifo_push) fq.push_back(fifo_wdata);
        if (fifo_pop && fq.size() > 0) fifo_rdata <= fq.pop_front();
        fcnt <= fq.size();
    end

    // ---------------- transmitter model ----------------
    int   tx_len = 3;
    int   rem = 0;
    logic hold_busy = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            rem     <= 0;
            tx_busy <= hold_busy;
        end else if (hold_busy) begin
            tx_busy <= 1'b1;
        end else if (tx_start) begin
            rem     <= tx_len;
            tx_busy <= 1'b1;
        end else if (rem > 1) begin
            rem <= rem - 1;
        end else begin
            rem     <= 0;
            tx_busy <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            last_w = N - 1;
    int            last_rr = N - 1;
    logic [DB-1:0] exp_tx [$];
    logic [DB-1:0] inflight = '0;
    bit            inflight_v = 1'b0;
    int            pop_cyc = 0;
    logic [N-1:0]  seen_grant = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Reference arbiter: the next producer served is the first pending one
    // after the producer served last, cycling through the producer list.
    function automatic int model_winner(input logic [N-1:0] r);
        int c;
        if (PRIO) begin
            if (r[0]) return 0;
            for (int k = 1; k < N; k++) begin
                c = ((last_rr - 1 + k) % (N - 1)) + 1;
                if (r[c]) return c;
            end
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            c = (last_w + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic exp_push;
        int   w;
        cyc++;
        exp_push = !reset && !fifo_full && (req != '0) && !fifo_pop;
        check("push_enable", {31'b0, fifo_push}, {31'b0, exp_push});
        if (fifo_pop) check("push_pop_excl", {31'b0, fifo_push}, 32'd0);
        if (fifo_push) begin
            w = model_winner(req);
            if (w < 0) begin
                note_fail("push_without_req");
            end else begin
                check("grant_onehot", {28'b0, grant}, 32'(1) << w);
                check("fifo_wdata", {24'b0, fifo_wdata}, {24'b0, pdata[w]});
                exp_tx.push_back(pdata[w]);
                if (PRIO) begin
                    if (w != 0) last_rr = w;
                end else begin
                    last_w = w;
                end
            end
        end else begin
            check("grant_idle", {28'b0, grant}, 32'd0);
        end
        seen_grant = grant;
        if (fifo_pop) begin
            check("pop_while_busy", {31'b0, tx_busy}, 32'd0);
            if (exp_tx.size() == 0) begin
                note_fail("pop_on_empty_model");
            end else begin
                inflight   = exp_tx.pop_front();
                inflight_v = 1'b1;
                pop_cyc    = cyc;
            end
        end
        if (tx_start) begin
            if (!inflight_v) begin
                note_fail("start_without_pop");
            end else begin
                check("tx_data", {24'b0, tx_data}, {24'b0, inflight});
                check("pop_to_start", cyc - pop_cyc, 32'd2);
                inflight_v = 1'b0;
            end
        end
        if (reset) begin
            inflight_v = 1'b0;
            last_w     = N - 1;
            last_rr    = N - 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drained(input int budget, input string nm);
        int i;
        for (i = 0; i < budget; i++) begin
            tick();
            if (exp_tx.size() == 0 && !inflight_v && fcnt == 0 && !tx_busy) break;
        end
        if (i == budget) note_fail(nm);
        repeat (3) tick();
    endtask

    task automatic auto_prod();
        for (int i = 0; i < N; i++) begin
            if (seen_grant[i]) begin
                if ($urandom_range(0, 1) == 1) pdata[i] = DB'($urandom);
                else req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                req[i]   = 1'b1;
                pdata[i] = DB'($urandom);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DB-1:0] rbytes [3];
        bit            got;
        reset     = 1'b1;
        hold_busy = 1'b1;
        req       = 4'b1111;
        for (int i = 0; i < N; i++) pdata[i] = DB'(8'hA0 + i);

        // reset: outputs quiet even with every producer requesting
        repeat (3) begin
            tick();
            @(negedge clk);
            check("rst_grant", {28'b0, grant}, 32'd0);
            check("rst_push", {31'b0, fifo_push}, 32'd0);
            check("rst_pop", {31'b0, fifo_pop}, 32'd0);
            check("rst_start", {31'b0, tx_start}, 32'd0);
            check("rst_tx_data", {24'b0, tx_data}, 32'd0);
        end
        tick();
        reset = 1'b0;

        if (!PRIO) begin
            // round robin with all producers held
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("rr_grant", {28'b0, grant}, 32'(1) << (i % N));
                check("rr_wdata", {24'b0, fifo_wdata}, 32'(8'hA0 + (i % N)));
                tick();
            end
        end else begin
            req = 4'b1011;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("prio_grant0", {28'b0, grant}, 32'd1);
                tick();
            end
            req = 4'b1010;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("prio_alt", {28'b0, grant}, (i % 2 == 0) ? 32'd2 : 32'd8);
                tick();
            end
        end
        req = '0;

        // full stall, then grant in the cycle full drops
        tick();
        req        = 4'b0100;
        pdata[2]   = 8'h77;
        force_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_grant", {28'b0, grant}, 32'd0);
            check("full_push", {31'b0, fifo_push}, 32'd0);
            tick();
        end
        force_full = 1'b0;
        @(negedge clk);
        check("unfull_grant", {28'b0, grant}, 32'd4);
        check("unfull_wdata", {24'b0, fifo_wdata}, 32'h77);
        tick();
        req = '0;

        // drain everything queued so far
        hold_busy = 1'b0;
        tx_len    = 2;
        wait_drained(300, "drain1_timeout");

        // drain latency, pop/push collision, busy hold-off
        tx_len   = 10;
        req      = 4'b0010;
        pdata[1] = 8'h55;
        @(negedge clk);
        check("d_grant1", {28'b0, grant}, 32'd2);
        tick();
        req        = 4'b0100;
        pdata[2]   = 8'h66;
        force_full = 1'b1;
        @(negedge clk);
        check("d_pre_pop", {31'b0, fifo_pop}, 32'd0);
        tick();
        force_full = 1'b0;
        @(negedge clk);
        check("d_pop", {31'b0, fifo_pop}, 32'd1);
        check("coll_grant", {28'b0, grant}, 32'd0);
        tick();
        @(negedge clk);
        check("coll_next_grant", {28'b0, grant}, 32'd4);
        check("coll_next_wdata", {24'b0, fifo_wdata}, 32'h66);
        tick();
        req = '0;
        @(negedge clk);
        check("d_start", {31'b0, tx_start}, 32'd1);
        check("d_tx_data", {24'b0, tx_data}, 32'h55);
        for (int i = 0; i < 12; i++) begin
            tick();
            @(negedge clk);
            if (tx_busy) check("busy_no_pop", {31'b0, fifo_pop}, 32'd0);
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            @(negedge clk);
            if (tx_start) begin
                check("d_second", {24'b0, tx_data}, 32'h66);
                got = 1'b1;
            end
        end
        if (!got) note_fail("d_second_timeout");
        wait_drained(100, "drain2_timeout");

        // reset while waiting for the transmitter to acknowledge
        tick();
        hold_busy = 1'b1;
        tick();
        rbytes = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            req      = 4'b0001;
            pdata[0] = rbytes[i];
            @(negedge clk);
            check("r_fill", {28'b0, grant}, 32'd1);
            tick();
        end
        req       = '0;
        tx_len    = 20;
        hold_busy = 1'b0;
        got       = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            @(negedge clk);
            if (tx_start) got = 1'b1;
        end
        if (!got) note_fail("r_first_start_timeout");
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("r_grant", {28'b0, grant}, 32'd0);
        check("r_push", {31'b0, fifo_push}, 32'd0);
        check("r_pop", {31'b0, fifo_pop}, 32'd0);
        check("r_start", {31'b0, tx_start}, 32'd0);
        check("r_tx_data", {24'b0, tx_data}, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 3 && !got; i++) begin
            tick();
            @(negedge clk);
            if (tx_start) begin
                check("r_restart_data", {24'b0, tx_data}, 32'h22);
                got = 1'b1;
            end
        end
        if (!got) note_fail("r_restart_late");
        tx_len = 2;
        wait_drained(200, "drain3_timeout");

        // randomized traffic with a shallow FIFO
        depth = 5;
        for (int c = 0; c < 1500; c++) begin
            tick();
            auto_prod();
            force_full = ($urandom_range(0, 7) == 0);
            tx_len     = $urandom_range(1, 6);
        end
        tick();
        req        = '0;
        force_full = 1'b0;
        wait_drained(600, "drain_rand_timeout");
        check("final_queue", exp_tx.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
